// File: rtl/commit_unit_if.sv
// commit_unit_if: bundles the commit-side bus of commit_unit.
//   master : upstream/environment side (drives ROB commit slots and mem_ready,
//            observes every retire output).
//   slave  : the commit unit itself.
// Signals: commit_valid/uid/loc/val, commit_ready, rf_we/waddr/wdata,
//          mem_we/addr/wdata, mem_ready, flush_all, redirect_pc, halted,
//          retired_count, overflow_err.
interface commit_unit_if #(
   parameter int COMMIT_WIDTH = 2,
   parameter int UID_BITS     = 3,
   parameter int REG_BITS     = 3
);
   logic [COMMIT_WIDTH-1:0]          commit_valid;
   logic [COMMIT_WIDTH*UID_BITS-1:0] commit_uid;
   logic [COMMIT_WIDTH*18-1:0]       commit_loc;
   logic [COMMIT_WIDTH*16-1:0]       commit_val;
   logic                             commit_ready;
   logic                             rf_we;
   logic [REG_BITS-1:0]              rf_waddr;
   logic [15:0]                      rf_wdata;
   logic                             mem_we;
   logic [15:0]                      mem_addr;
   logic [15:0]                      mem_wdata;
   logic                             mem_ready;
   logic                             flush_all;
   logic [15:0]                      redirect_pc;
   logic                             halted;
   logic [15:0]                      retired_count;
   logic                             overflow_err;

   modport master (
      output commit_valid, commit_uid, commit_loc, commit_val, mem_ready,
      input  commit_ready, rf_we, rf_waddr, rf_wdata, mem_we, mem_addr,
             mem_wdata, flush_all, redirect_pc, halted, retired_count,
             overflow_err
   );

   modport slave (
      input  commit_valid, commit_uid, commit_loc, commit_val, mem_ready,
      output commit_ready, rf_we, rf_waddr, rf_wdata, mem_we, mem_addr,
             mem_wdata, flush_all, redirect_pc, halted, retired_count,
             overflow_err
   );
endinterface

// File: rtl/commit_unit.sv
// commit_unit: buffers in-order committed ROB entries in a small FIFO and
// retires one per cycle as a register write, store, jump (flush) or halt.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - commit_unit_if.slave: ROB commit slots in, retire strobes out,
//          mem_ready in, status (halted, retired_count, overflow_err) out.
module commit_unit #(
   parameter int COMMIT_WIDTH = 2,
   parameter int DEPTH        = 8,
   parameter int UID_BITS     = 3,
   parameter int REG_BITS     = 3
) (
   input  logic          clk,
   input  logic          rst,
   commit_unit_if.slave  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   localparam logic [1:0] T_REG   = 2'b00;
   localparam logic [1:0] T_STORE = 2'b01;
   localparam logic [1:0] T_JUMP  = 2'b10;

   typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;

   state_t              state_q, state_d;
   logic [PW-1:0]       head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]       count_q, count_d;
   logic                ovf_q, ovf_d;
   logic [15:0]         retired_q;
   logic                halted_q;
   logic                rf_we_q, mem_we_q;
   logic [REG_BITS-1:0] rf_waddr_q;
   logic [15:0]         rf_wdata_q, mem_addr_q, mem_wdata_q, redirect_q;

   // uid is trace-only, so only loc and val are kept per entry
   logic [17:0]         loc_mem [DEPTH];
   logic [15:0]         val_mem [DEPTH];

   logic [17:0]         head_loc;
   logic [15:0]         head_val;
   logic                do_pop, jump_pop;
   int                  n_valid, n_free, n_push;

   assign head_loc = loc_mem[head_q];
   assign head_val = val_mem[head_q];

   always_comb begin
      n_valid  = 0;
      for (int s = 0; s < COMMIT_WIDTH; s++) n_valid += int'(bus.commit_valid[s]);
      n_free   = DEPTH - int'(count_q);

      // a store at the head blocks retire until memory accepts it
      do_pop   = (state_q == RUN) && (count_q != '0) &&
                 ((head_loc[17:16] != T_STORE) || bus.mem_ready);
      jump_pop = do_pop && (head_loc[17:16] == T_JUMP);

      // pushes coinciding with a jump retire are younger work: discard them
      n_push = 0;
      ovf_d  = ovf_q;
      if (state_q == RUN && !jump_pop) begin
         n_push = (n_valid < n_free) ? n_valid : n_free;
         if (n_valid > n_free) ovf_d = 1'b1;
      end

      head_d  = do_pop ? head_q + PW'(1) : head_q;
      tail_d  = tail_q + PW'(n_push);
      count_d = CW'(int'(count_q) + n_push - (do_pop ? 1 : 0));
      if (jump_pop) begin
         tail_d  = head_d;
         count_d = '0;
      end

      state_d = state_q;
      case (state_q)
         RUN:     if (do_pop && head_loc[17:16] == T_JUMP)       state_d = FLUSH;
                  else if (do_pop && head_loc[17:16] == 2'b11)   state_d = HALT;
         FLUSH:   state_d = RUN;
         default: state_d = HALT;
      endcase
   end

   always_ff @(posedge clk) begin
      for (int s = 0; s < COMMIT_WIDTH; s++) begin
         if (s < n_push) begin
            loc_mem[tail_q + PW'(s)] <= bus.commit_loc[s*18 +: 18];
            val_mem[tail_q + PW'(s)] <= bus.commit_val[s*16 +: 16];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         ovf_q       <= 1'b0;
         retired_q   <= '0;
         halted_q    <= 1'b0;
         rf_we_q     <= 1'b0;
         mem_we_q    <= 1'b0;
         rf_waddr_q  <= '0;
         rf_wdata_q  <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         redirect_q  <= '0;
      end else begin
         state_q   <= state_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         rf_we_q   <= do_pop && head_loc[17:16] == T_REG;
         mem_we_q  <= do_pop && head_loc[17:16] == T_STORE;
         if (do_pop) retired_q <= retired_q + 16'd1;
         if (do_pop && head_loc[17:16] == T_REG) begin
            rf_waddr_q <= head_loc[REG_BITS-1:0];
            rf_wdata_q <= head_val;
         end
         if (do_pop && head_loc[17:16] == T_STORE) begin
            mem_addr_q  <= head_loc[15:0];
            mem_wdata_q <= head_val;
         end
         if (jump_pop) redirect_q <= head_val;
         if (state_d == HALT) halted_q <= 1'b1;
      end
   end

   // ready reflects start-of-cycle occupancy; a same-cycle pop doesn't count
   assign bus.commit_ready  = (n_free >= COMMIT_WIDTH);
   assign bus.rf_we         = rf_we_q;
   assign bus.rf_waddr      = rf_waddr_q;
   assign bus.rf_wdata      = rf_wdata_q;
   assign bus.mem_we        = mem_we_q;
   assign bus.mem_addr      = mem_addr_q;
   assign bus.mem_wdata     = mem_wdata_q;
   assign bus.flush_all     = (state_q == FLUSH);
   assign bus.redirect_pc   = redirect_q;
   assign bus.halted        = halted_q;
   assign bus.retired_count = retired_q;
   assign bus.overflow_err  = ovf_q;
endmodule

// File: tb/tb_commit_unit.sv
// tb_commit_unit: directed, self-checking bench for commit_unit.
module tb_commit_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   commit_unit_if #(.COMMIT_WIDTH(2), .UID_BITS(3), .REG_BITS(3)) bus ();

   commit_unit #(.COMMIT_WIDTH(2), .DEPTH(8), .UID_BITS(3), .REG_BITS(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // advance one clock; inputs change and outputs are sampled 1ns after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      bus.commit_valid = '0;
      bus.commit_uid   = '0;
      bus.commit_loc   = '0;
      bus.commit_val   = '0;
   endtask

   task automatic push1(input logic [17:0] l, input logic [15:0] v);
      bus.commit_valid = 2'b01;
      bus.commit_uid   = 6'd1;
      bus.commit_loc   = {18'h0, l};
      bus.commit_val   = {16'h0, v};
   endtask

   task automatic push2(input logic [17:0] l0, input logic [15:0] v0,
                        input logic [17:0] l1, input logic [15:0] v1);
      bus.commit_valid = 2'b11;
      bus.commit_uid   = {3'd3, 3'd2};
      bus.commit_loc   = {l1, l0};
      bus.commit_val   = {v1, v0};
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_in();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      step();
      checks++; if (bus.commit_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.commit_ready); end
      checks++; if ({bus.rf_we, bus.mem_we, bus.flush_all} !== 3'b000) begin errors++; $display("FAIL reset_strobes got=%b exp=000", {bus.rf_we, bus.mem_we, bus.flush_all}); end
      checks++; if (bus.halted !== 1'b0 || bus.overflow_err !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", bus.halted, bus.overflow_err); end
      checks++; if (bus.retired_count !== 16'd0 || bus.redirect_pc !== 16'd0) begin errors++; $display("FAIL reset_regs got=%h/%h exp=0/0", bus.retired_count, bus.redirect_pc); end
   endtask

   task automatic test_regwrite();
      push1(18'h00005, 16'h1234);
      step();
      clear_in();
      checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL rw_early got=%b exp=0", bus.rf_we); end
      step();
      checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 3'd5 || bus.rf_wdata !== 16'h1234) begin errors++; $display("FAIL rw_strobe got=%b/%h/%h exp=1/5/1234", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
      checks++; if (bus.retired_count !== 16'd1) begin errors++; $display("FAIL rw_count got=%0d exp=1", bus.retired_count); end
      step();
      checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL rw_oneshot got=%b exp=0", bus.rf_we); end
   endtask

   task automatic test_store_stall();
      bus.mem_ready = 1'b0;
      push1(18'h10040, 16'hBEEF);
      step();
      clear_in();
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL st_stall%0d got=%b exp=0", i, bus.mem_we); end
      end
      bus.mem_ready = 1'b1;
      step();
      checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 16'h0040 || bus.mem_wdata !== 16'hBEEF) begin errors++; $display("FAIL st_strobe got=%b/%h/%h exp=1/0040/beef", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
      checks++; if (bus.retired_count !== 16'd2) begin errors++; $display("FAIL st_count got=%0d exp=2", bus.retired_count); end
      step();
      checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL st_oneshot got=%b exp=0", bus.mem_we); end
   endtask

   task automatic test_jump_flush();
      push2(18'h20000, 16'h0100, 18'h00007, 16'h5555);
      step();
      push1(18'h00003, 16'h7777);   // lands on the jump's pop edge
      step();
      clear_in();
      checks++; if (bus.flush_all !== 1'b1 || bus.redirect_pc !== 16'h0100) begin errors++; $display("FAIL jmp_flush got=%b/%h exp=1/0100", bus.flush_all, bus.redirect_pc); end
      checks++; if (bus.retired_count !== 16'd3) begin errors++; $display("FAIL jmp_count got=%0d exp=3", bus.retired_count); end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (bus.flush_all !== 1'b0 || bus.rf_we !== 1'b0) begin errors++; $display("FAIL jmp_after%0d got=%b%b exp=00", i, bus.flush_all, bus.rf_we); end
      end
      checks++; if (bus.retired_count !== 16'd3 || bus.commit_ready !== 1'b1) begin errors++; $display("FAIL jmp_empty got=%0d/%b exp=3/1", bus.retired_count, bus.commit_ready); end
      push1(18'h00002, 16'hAAAA);
      step();
      clear_in();
      step();
      checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 3'd2 || bus.rf_wdata !== 16'hAAAA) begin errors++; $display("FAIL jmp_resume got=%b/%h/%h exp=1/2/aaaa", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
   endtask

   task automatic test_halt();
      push2(18'h30000, 16'h0000, 18'h00001, 16'h1111);
      step();
      clear_in();
      step();
      checks++; if (bus.halted !== 1'b1 || bus.retired_count !== 16'd5) begin errors++; $display("FAIL halt_set got=%b/%0d exp=1/5", bus.halted, bus.retired_count); end
      push1(18'h00006, 16'h6666);
      step();
      clear_in();
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (bus.halted !== 1'b1 || bus.rf_we !== 1'b0 || bus.retired_count !== 16'd5) begin errors++; $display("FAIL halt_hold%0d got=%b/%b/%0d exp=1/0/5", i, bus.halted, bus.rf_we, bus.retired_count); end
      end
      do_reset();
      checks++; if (bus.halted !== 1'b0 || bus.retired_count !== 16'd0) begin errors++; $display("FAIL halt_rst got=%b/%0d exp=0/0", bus.halted, bus.retired_count); end
   endtask

   task automatic test_full_overflow();
      // retire one entry first so head starts at 1 and the ring wraps
      push1(18'h00004, 16'h4444);
      step();
      clear_in();
      step();
      bus.mem_ready = 1'b0;
      push2(18'h10010, 16'd1, 18'h10011, 16'd2); step();
      push2(18'h10012, 16'd3, 18'h10013, 16'd4); step();
      push2(18'h10014, 16'd5, 18'h10015, 16'd6); step();
      checks++; if (bus.commit_ready !== 1'b1) begin errors++; $display("FAIL full_c6 got=%b exp=1", bus.commit_ready); end
      push1(18'h10016, 16'd7); step();
      checks++; if (bus.commit_ready !== 1'b0 || bus.overflow_err !== 1'b0) begin errors++; $display("FAIL full_c7 got=%b/%b exp=0/0", bus.commit_ready, bus.overflow_err); end
      push2(18'h10017, 16'd8, 18'h10018, 16'd9); step();
      clear_in();
      checks++; if (bus.commit_ready !== 1'b0 || bus.overflow_err !== 1'b1) begin errors++; $display("FAIL full_c8 got=%b/%b exp=0/1", bus.commit_ready, bus.overflow_err); end
      bus.mem_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 16'h0010 + 16'(i) || bus.mem_wdata !== 16'(i + 1)) begin errors++; $display("FAIL drain%0d got=%b/%h/%h exp=1/%h/%h", i, bus.mem_we, bus.mem_addr, bus.mem_wdata, 16'h0010 + 16'(i), 16'(i + 1)); end
         if (i == 0) begin
            checks++; if (bus.commit_ready !== 1'b0) begin errors++; $display("FAIL drain_ready got=%b exp=0", bus.commit_ready); end
         end
      end
      step();
      checks++; if (bus.mem_we !== 1'b0 || bus.retired_count !== 16'd9) begin errors++; $display("FAIL drain_end got=%b/%0d exp=0/9", bus.mem_we, bus.retired_count); end
   endtask

   task automatic test_reset_mid_stall();
      bus.mem_ready = 1'b0;
      push2(18'h10020, 16'hCAFE, 18'h00001, 16'h0001); step();
      push2(18'h00002, 16'h0002, 18'h00003, 16'h0003); step();
      push1(18'h00004, 16'h0004); step();
      clear_in();
      bus.mem_ready = 1'b1;
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if ({bus.mem_we, bus.rf_we, bus.flush_all, bus.halted, bus.overflow_err} !== 5'b0 || bus.retired_count !== 16'd0 || bus.commit_ready !== 1'b1) begin errors++; $display("FAIL rstmid_out got=%b/%0d/%b exp=00000/0/1", {bus.mem_we, bus.rf_we, bus.flush_all, bus.halted, bus.overflow_err}, bus.retired_count, bus.commit_ready); end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (bus.mem_we !== 1'b0 || bus.rf_we !== 1'b0 || bus.retired_count !== 16'd0) begin errors++; $display("FAIL rstmid_quiet%0d got=%b%b/%0d exp=00/0", i, bus.mem_we, bus.rf_we, bus.retired_count); end
      end
   endtask

   initial begin
      clear_in();
      bus.mem_ready = 1'b1;
      test_reset();
      test_regwrite();
      test_store_stall();
      test_jump_flush();
      test_halt();
      test_full_overflow();
      test_reset_mid_stall();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
